// File: rtl/lcd_bus_decoder.sv
// lcd_bus_decoder: passive tap on an 8080-style LCD write bus.
// Decodes ILI9341-style CASET/PASET/RAMWR traffic and rebuilds every RGB565
// pixel write as (x, y, RGB444) so the LCD stream can be compared on-chip
// with the VGA chain. Only listens to the bus; it never drives it.
module lcd_bus_decoder #(
  parameter int WIDTH       = 320,
  parameter int HEIGHT      = 240,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic [7:0]                lcd_db,
  input  logic                      lcd_wr,
  input  logic                      lcd_d_c,
  input  logic                      lcd_rd,
  input  logic                      lcd_reset,
  output logic                      cmd_valid,
  output logic [7:0]                cmd_code,
  output logic                      frame_start,
  output logic                      pxl_valid,
  output logic [$clog2(WIDTH)-1:0]  pxl_x,
  output logic [$clog2(HEIGHT)-1:0] pxl_y,
  output logic [11:0]               pxl_rgb,
  output logic                      protocol_err
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam logic [15:0]   W_LIM  = 16'(WIDTH);
  localparam logic [15:0]   H_LIM  = 16'(HEIGHT);
  localparam logic [XW-1:0] EC_RST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] EP_RST = YW'(HEIGHT - 1);
  // Bus bundle is {lcd_reset, lcd_rd, lcd_d_c, lcd_wr, lcd_db}. The idle
  // pattern holds reset/rd/wr high so leaving reset never fakes a write edge.
  localparam logic [11:0]   BUS_IDLE = 12'hD00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET,
    ST_PASET,
    ST_RAMWR,
    ST_IGNORE
  } state_t;

  logic [11:0] sync_reg [SYNC_STAGES];
  logic        wr_prev_reg;

  logic [11:0] bus_s;
  logic [7:0]  db_s;
  logic        wr_s, dc_s, rd_s, rst_s, wr_event;

  assign bus_s    = sync_reg[SYNC_STAGES-1];
  assign db_s     = bus_s[7:0];
  assign wr_s     = bus_s[8];
  assign dc_s     = bus_s[9];
  assign rd_s     = bus_s[10];
  assign rst_s    = bus_s[11];
  assign wr_event = wr_s & ~wr_prev_reg;

  state_t          state_reg, state_next;
  logic [2:0]      cnt_reg, cnt_next;
  logic [7:0]      par0_reg, par0_next, par1_reg, par1_next, par2_reg, par2_next;
  logic [XW-1:0]   sc_reg, sc_next, ec_reg, ec_next;
  logic [YW-1:0]   sp_reg, sp_next, ep_reg, ep_next;
  logic [XW-1:0]   cur_x_reg, cur_x_next;
  logic [YW-1:0]   cur_y_reg, cur_y_next;
  logic            half_reg, half_next;
  logic [7:0]      hi_reg, hi_next;
  logic            cmd_valid_reg, cmd_valid_next;
  logic [7:0]      cmd_code_reg, cmd_code_next;
  logic            frame_start_reg, frame_start_next;
  logic            pxl_valid_reg, pxl_valid_next;
  logic [XW-1:0]   pxl_x_reg, pxl_x_next;
  logic [YW-1:0]   pxl_y_reg, pxl_y_next;
  logic [11:0]     pxl_rgb_reg, pxl_rgb_next;
  logic            err_reg, err_next;

  // Window parameters as they arrive: {hi,lo} of start, {hi,lo} of end.
  logic [15:0] win_start, win_end;
  logic [11:0] rgb444;
  assign win_start = {par0_reg, par1_reg};
  assign win_end   = {par2_reg, db_s};
  // RGB565 {R5,G6,B5} over hi/lo bytes, reduced to the top 4 bits of each.
  assign rgb444    = {hi_reg[7:4], hi_reg[2:0], db_s[7], db_s[4:1]};

  // Input synchronisers plus the delayed write strobe for edge detection.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= BUS_IDLE;
      wr_prev_reg <= 1'b1;
    end else begin
      sync_reg[0] <= {lcd_reset, lcd_rd, lcd_d_c, lcd_wr, lcd_db};
      for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
      wr_prev_reg <= wr_s;
    end
  end

  // Decoder state and output registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= '0;
      par0_reg        <= '0;
      par1_reg        <= '0;
      par2_reg        <= '0;
      sc_reg          <= '0;
      ec_reg          <= EC_RST;
      sp_reg          <= '0;
      ep_reg          <= EP_RST;
      cur_x_reg       <= '0;
      cur_y_reg       <= '0;
      half_reg        <= 1'b0;
      hi_reg          <= '0;
      cmd_valid_reg   <= 1'b0;
      cmd_code_reg    <= '0;
      frame_start_reg <= 1'b0;
      pxl_valid_reg   <= 1'b0;
      pxl_x_reg       <= '0;
      pxl_y_reg       <= '0;
      pxl_rgb_reg     <= '0;
      err_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      par0_reg        <= par0_next;
      par1_reg        <= par1_next;
      par2_reg        <= par2_next;
      sc_reg          <= sc_next;
      ec_reg          <= ec_next;
      sp_reg          <= sp_next;
      ep_reg          <= ep_next;
      cur_x_reg       <= cur_x_next;
      cur_y_reg       <= cur_y_next;
      half_reg        <= half_next;
      hi_reg          <= hi_next;
      cmd_valid_reg   <= cmd_valid_next;
      cmd_code_reg    <= cmd_code_next;
      frame_start_reg <= frame_start_next;
      pxl_valid_reg   <= pxl_valid_next;
      pxl_x_reg       <= pxl_x_next;
      pxl_y_reg       <= pxl_y_next;
      pxl_rgb_reg     <= pxl_rgb_next;
      err_reg         <= err_next;
    end
  end

  // Next-state decode: soft reset first, otherwise act only on write events.
  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    par0_next        = par0_reg;
    par1_next        = par1_reg;
    par2_next        = par2_reg;
    sc_next          = sc_reg;
    ec_next          = ec_reg;
    sp_next          = sp_reg;
    ep_next          = ep_reg;
    cur_x_next       = cur_x_reg;
    cur_y_next       = cur_y_reg;
    half_next        = half_reg;
    hi_next          = hi_reg;
    cmd_valid_next   = 1'b0;
    cmd_code_next    = cmd_code_reg;
    frame_start_next = 1'b0;
    pxl_valid_next   = 1'b0;
    pxl_x_next       = pxl_x_reg;
    pxl_y_next       = pxl_y_reg;
    pxl_rgb_next     = pxl_rgb_reg;
    err_next         = 1'b0;

    if (!rst_s) begin
      // LCD reset pin low: same values as the asynchronous reset.
      state_next    = ST_IDLE;
      cnt_next      = '0;
      par0_next     = '0;
      par1_next     = '0;
      par2_next     = '0;
      sc_next       = '0;
      ec_next       = EC_RST;
      sp_next       = '0;
      ep_next       = EP_RST;
      cur_x_next    = '0;
      cur_y_next    = '0;
      half_next     = 1'b0;
      hi_next       = '0;
      cmd_code_next = '0;
      pxl_x_next    = '0;
      pxl_y_next    = '0;
      pxl_rgb_next  = '0;
    end else if (wr_event) begin
      // A read strobe overlapping a write is flagged, but the byte is used.
      if (!rd_s) err_next = 1'b1;

      if (!dc_s) begin
        cmd_code_next  = db_s;
        cmd_valid_next = 1'b1;
        if (state_reg == ST_RAMWR && half_reg) err_next = 1'b1;
        if ((state_reg == ST_CASET || state_reg == ST_PASET) && cnt_reg < 3'd4)
          err_next = 1'b1;
        half_next = 1'b0;
        cnt_next  = '0;
        case (db_s)
          8'h2A:   state_next = ST_CASET;
          8'h2B:   state_next = ST_PASET;
          8'h2C: begin
            state_next       = ST_RAMWR;
            cur_x_next       = sc_reg;
            cur_y_next       = sp_reg;
            frame_start_next = 1'b1;
          end
          default: state_next = ST_IGNORE;
        endcase
      end else begin
        case (state_reg)
          ST_IDLE: err_next = 1'b1;
          ST_CASET, ST_PASET: begin
            if (cnt_reg < 3'd4) begin
              cnt_next = cnt_reg + 3'd1;
              case (cnt_reg)
                3'd0: par0_next = db_s;
                3'd1: par1_next = db_s;
                3'd2: par2_next = db_s;
                default: begin
                  if (state_reg == ST_CASET) begin
                    if (win_start <= win_end && win_end < W_LIM) begin
                      sc_next = win_start[XW-1:0];
                      ec_next = win_end[XW-1:0];
                    end else begin
                      err_next = 1'b1;
                    end
                  end else begin
                    if (win_start <= win_end && win_end < H_LIM) begin
                      sp_next = win_start[YW-1:0];
                      ep_next = win_end[YW-1:0];
                    end else begin
                      err_next = 1'b1;
                    end
                  end
                end
              endcase
            end
          end
          ST_RAMWR: begin
            if (!half_reg) begin
              hi_next   = db_s;
              half_next = 1'b1;
            end else begin
              half_next      = 1'b0;
              pxl_valid_next = 1'b1;
              pxl_x_next     = cur_x_reg;
              pxl_y_next     = cur_y_reg;
              pxl_rgb_next   = rgb444;
              if (cur_x_reg != ec_reg) begin
                cur_x_next = cur_x_reg + XW'(1);
              end else begin
                cur_x_next = sc_reg;
                cur_y_next = (cur_y_reg != ep_reg) ? cur_y_reg + YW'(1) : sp_reg;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign cmd_valid    = cmd_valid_reg;
  assign cmd_code     = cmd_code_reg;
  assign frame_start  = frame_start_reg;
  assign pxl_valid    = pxl_valid_reg;
  assign pxl_x        = pxl_x_reg;
  assign pxl_y        = pxl_y_reg;
  assign pxl_rgb      = pxl_rgb_reg;
  assign protocol_err = err_reg;

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Bench for lcd_bus_decoder: drives 8080 bus writes, predicts the decoded
// events with a window/pixel-index model and checks them in a scoreboard.
module tb_lcd_bus_decoder;

  localparam int WIDTH  = 320;
  localparam int HEIGHT = 240;
  localparam int XW     = $clog2(WIDTH);
  localparam int YW     = $clog2(HEIGHT);

  logic          clk;
  logic          resetN;
  logic [7:0]    lcd_db;
  logic          lcd_wr, lcd_d_c, lcd_rd, lcd_reset;
  logic          cmd_valid;
  logic [7:0]    cmd_code;
  logic          frame_start, pxl_valid, protocol_err;
  logic [XW-1:0] pxl_x;
  logic [YW-1:0] pxl_y;
  logic [11:0]   pxl_rgb;

  lcd_bus_decoder #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .SYNC_STAGES(2)) dut (
    .clk(clk), .resetN(resetN), .lcd_db(lcd_db), .lcd_wr(lcd_wr),
    .lcd_d_c(lcd_d_c), .lcd_rd(lcd_rd), .lcd_reset(lcd_reset),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .frame_start(frame_start),
    .pxl_valid(pxl_valid), .pxl_x(pxl_x), .pxl_y(pxl_y), .pxl_rgb(pxl_rgb),
    .protocol_err(protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          cmd;
    logic [7:0]    code;
    logic          fs;
    logic          pv;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [11:0]   rgb;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state: last command, collected params, window, pixel index.
  int         last_cmd;
  int         params[$];
  int         m_sc, m_ec, m_sp, m_ep;
  int         pix_n;
  bit         have_hi;
  int         hi_byte;

  function automatic void chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  function automatic void model_reset();
    last_cmd = -1;
    params.delete();
    m_sc = 0; m_ec = WIDTH - 1;
    m_sp = 0; m_ep = HEIGHT - 1;
    pix_n = 0;
    have_hi = 0;
    hi_byte = 0;
  endfunction

  function automatic void model_write(bit dc, int d, bit rd_low);
    exp_t r;
    bit   err;
    int   s, e, lim, w, h, r5, g6, b5;
    r   = '0;
    err = rd_low;
    if (!dc) begin
      if (last_cmd == 'h2C && have_hi) err = 1;
      if ((last_cmd == 'h2A || last_cmd == 'h2B) && params.size() < 4) err = 1;
      params.delete();
      have_hi  = 0;
      last_cmd = d;
      r.cmd    = 1;
      r.code   = 8'(d);
      if (d == 'h2C) begin
        pix_n = 0;
        r.fs  = 1;
      end
    end else if (last_cmd < 0) begin
      err = 1;
    end else if (last_cmd == 'h2A || last_cmd == 'h2B) begin
      if (params.size() < 4) begin
        params.push_back(d);
        if (params.size() == 4) begin
          s   = params[0] * 256 + params[1];
          e   = params[2] * 256 + params[3];
          lim = (last_cmd == 'h2A) ? WIDTH : HEIGHT;
          if (s <= e && e < lim) begin
            if (last_cmd == 'h2A) begin m_sc = s; m_ec = e; end
            else begin m_sp = s; m_ep = e; end
          end else begin
            err = 1;
          end
        end
      end
    end else if (last_cmd == 'h2C) begin
      if (!have_hi) begin
        hi_byte = d;
        have_hi = 1;
      end else begin
        have_hi = 0;
        w  = m_ec - m_sc + 1;
        h  = m_ep - m_sp + 1;
        r.pv = 1;
        r.x  = XW'(m_sc + pix_n % w);
        r.y  = YW'(m_sp + (pix_n / w) % h);
        pix_n++;
        r5 = hi_byte >> 3;
        g6 = ((hi_byte & 7) << 3) | (d >> 5);
        b5 = d & 31;
        r.rgb = 12'(((r5 >> 1) << 8) | ((g6 >> 2) << 4) | (b5 >> 1));
      end
    end
    if (r.cmd || r.fs || r.pv || err) begin
      r.err = err;
      exp_q.push_back(r);
    end
  endfunction

  // Scoreboard monitor: every output pulse consumes one expected record.
  always @(negedge clk) begin : monitor
    exp_t e;
    bit   ok;
    if (resetN && (cmd_valid || frame_start || pxl_valid || protocol_err)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse actual cmd=%0b fs=%0b pv=%0b err=%0b required no pulse",
                 cmd_valid, frame_start, pxl_valid, protocol_err);
      end else begin
        e  = exp_q.pop_front();
        ok = (cmd_valid == e.cmd) && (frame_start == e.fs) && (pxl_valid == e.pv) &&
             (protocol_err == e.err) && (!e.cmd || cmd_code == e.code) &&
             (!e.pv || (pxl_x == e.x && pxl_y == e.y && pxl_rgb == e.rgb));
        if (ok) begin
          $display("txn cmd=%0b code=%02h fs=%0b pv=%0b xy=(%0d,%0d) rgb=%03h err=%0b",
                   cmd_valid, cmd_code, frame_start, pxl_valid, pxl_x, pxl_y, pxl_rgb,
                   protocol_err);
        end else begin
          errors++;
          $display("FAIL event actual cmd=%0b code=%02h fs=%0b pv=%0b xy=(%0d,%0d) rgb=%03h err=%0b required cmd=%0b code=%02h fs=%0b pv=%0b xy=(%0d,%0d) rgb=%03h err=%0b",
                   cmd_valid, cmd_code, frame_start, pxl_valid, pxl_x, pxl_y, pxl_rgb,
                   protocol_err, e.cmd, e.code, e.fs, e.pv, e.x, e.y, e.rgb, e.err);
        end
      end
    end
  end

  task automatic write_byte(input bit dc, input int d, input bit rd_low);
    @(negedge clk);
    lcd_d_c = dc;
    lcd_db  = 8'(d);
    lcd_rd  = !rd_low;
    lcd_wr  = 1'b0;
    repeat (2) @(negedge clk);
    model_write(dc, d, rd_low);
    lcd_wr = 1'b1;
    repeat (3) @(negedge clk);
    lcd_rd = 1'b1;
  endtask

  task automatic cmd(input int c);
    write_byte(1'b0, c, 1'b0);
  endtask

  task automatic dat(input int d);
    write_byte(1'b1, d, 1'b0);
  endtask

  task automatic pixel(input int w16);
    dat((w16 >> 8) & 'hFF);
    dat(w16 & 'hFF);
  endtask

  task automatic send_win(input int c, input int s, input int e, input int n);
    int b[4];
    b[0] = (s >> 8) & 'hFF; b[1] = s & 'hFF;
    b[2] = (e >> 8) & 'hFF; b[3] = e & 'hFF;
    write_byte(1'b0, c, ($urandom_range(0, 15) == 0));
    for (int i = 0; i < n; i++)
      write_byte(1'b1, (i < 4) ? b[i] : int'($urandom_range(0, 255)),
                 ($urandom_range(0, 15) == 0));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_cmd_valid"}, cmd_valid, 0);
    chk({tag, "_cmd_code"}, cmd_code, 0);
    chk({tag, "_frame_start"}, frame_start, 0);
    chk({tag, "_pxl_valid"}, pxl_valid, 0);
    chk({tag, "_pxl_x"}, pxl_x, 0);
    chk({tag, "_pxl_y"}, pxl_y, 0);
    chk({tag, "_pxl_rgb"}, pxl_rgb, 0);
    chk({tag, "_protocol_err"}, protocol_err, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0;
    #1;
    check_zero("async_reset");
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int r, s, e, lim, n;
    resetN    = 1'b0;
    lcd_db    = 8'h00;
    lcd_wr    = 1'b1;
    lcd_d_c   = 1'b0;
    lcd_rd    = 1'b1;
    lcd_reset = 1'b1;
    model_reset();
    do_reset();
    check_zero("post_reset");

    // Data byte with no command since reset.
    dat('h55);

    // Plan 1: default window, red pixel then second pixel.
    cmd('h2C);
    pixel('hF800);
    pixel('hF800);

    // Plan 2: 3x2 window with wrap back to the start.
    send_win('h2A, 10, 12, 4);
    send_win('h2B, 5, 6, 4);
    cmd('h2C);
    for (int i = 0; i < 7; i++) pixel('h07E0);

    // Plan 3: SC > EC rejected, old window kept.
    cmd('h2A); dat(0); dat(20); dat(0); dat(10);
    cmd('h2C);
    pixel('h001F);

    // Plan 4: half pixel cut off by a command.
    cmd('h2C);
    dat('hFF);
    cmd('h2A);
    send_win('h2A, 0, WIDTH - 1, 4);
    send_win('h2B, 0, HEIGHT - 1, 4);

    // Plan 5: soft reset mid-RAMWR, then async reset mid-pixel.
    cmd('h2C);
    pixel('h1234);
    dat('hAB);
    @(negedge clk);
    lcd_reset = 1'b0;
    repeat (10) @(negedge clk);
    lcd_reset = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    cmd('h2C);
    pixel('hFFFF);
    pixel('h8410);
    dat('hC3);
    do_reset();

    // Plan 6: unknown command with data bytes.
    cmd('h11);
    dat(1); dat(2); dat(3);

    // Randomised traffic.
    for (int it = 0; it < 200; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 1) begin
        lim = (r == 0) ? WIDTH : HEIGHT;
        case ($urandom_range(0, 7))
          0: begin s = $urandom_range(5, lim - 1); e = s - $urandom_range(1, 5); n = 4; end
          1: begin s = 0; e = lim - 1; n = $urandom_range(0, 3); end
          2: begin s = $urandom_range(0, 3); e = $urandom_range(lim, 600); n = 4; end
          default: begin
            s = $urandom_range(0, lim - 4);
            e = s + $urandom_range(0, 3);
            n = ($urandom_range(0, 3) == 0) ? 6 : 4;
          end
        endcase
        send_win((r == 0) ? 'h2A : 'h2B, s, e, n);
      end else if (r <= 6) begin
        write_byte(1'b0, 'h2C, ($urandom_range(0, 15) == 0));
        n = $urandom_range(0, 13);
        for (int i = 0; i < n; i++)
          write_byte(1'b1, $urandom_range(0, 255), ($urandom_range(0, 15) == 0));
      end else begin
        write_byte(1'b0, ($urandom_range(0, 1) == 0) ? 'h11 : int'($urandom_range(0, 255)),
                   ($urandom_range(0, 15) == 0));
        n = $urandom_range(0, 3);
        for (int i = 0; i < n; i++)
          write_byte(1'b1, $urandom_range(0, 255), ($urandom_range(0, 15) == 0));
      end
    end

    repeat (10) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_bus_decoder.md
Name: lcd_bus_decoder

Overview:
- Passive responder on the 8080-style parallel LCD write bus driven by the screen display block (lcd_db, lcd_wr, lcd_d_c, lcd_rd, lcd_reset).
- Decodes ILI9341-style command/parameter traffic: column set 0x2A, page set 0x2B, memory write 0x2C.
- Reconstructs each RGB565 pixel write as (x, y, RGB444) so the LCD stream can be checked on-chip against the VGA chain.
- Sits beside the LCD pins and taps them; it never drives the bus.

Parameters:
- WIDTH, 320, LCD columns; default window end column = WIDTH-1.
- HEIGHT, 240, LCD rows; default window end page = HEIGHT-1.
- SYNC_STAGES, 2, synchroniser flops on each bus input (minimum 2).

Ports:
- clk  in  1  sampling clock; must be ≥3× the lcd_wr toggle rate.
- resetN  in  1  asynchronous active-low reset.
- lcd_db  in  8  bus data.
- lcd_wr  in  1  write strobe; data is captured on its rising edge.
- lcd_d_c  in  1  0 = command byte, 1 = data/parameter byte.
- lcd_rd  in  1  read strobe; monitored for errors only.
- lcd_reset  in  1  LCD reset, active low.
- cmd_valid  out  1  one-cycle pulse per decoded command byte.
- cmd_code  out  8  last command byte.
- frame_start  out  1  one-cycle pulse on entry to RAMWR.
- pxl_valid  out  1  one-cycle pulse per completed pixel.
- pxl_x  out  $clog2(WIDTH)  pixel column.
- pxl_y  out  $clog2(HEIGHT)  pixel row.
- pxl_rgb  out  12  {R4,G4,B4}.
- protocol_err  out  1  one-cycle pulse per protocol violation.

Behaviour:

Reset and sampling:
- Reset (resetN=0, async): all outputs 0; state=IDLE; window SC=0, EC=WIDTH-1, SP=0, EP=HEIGHT-1; cursor=(0,0); byte counters cleared.
- lcd_db, lcd_wr and lcd_d_c each pass through SYNC_STAGES flops.
- A write event is a 0→1 transition of the synchronised lcd_wr. Synchronised lcd_db and lcd_d_c are sampled in that same cycle.
- Synchronised lcd_reset=0 acts as a synchronous soft reset with identical values to the async reset. Write events are ignored while it is low.

FSM, evaluated on write events only:
- Command byte (d_c=0), any state:
  - cmd_code <= byte; cmd_valid pulses the next cycle.
  - If a RAMWR pixel is half-received, the half pixel is discarded and protocol_err pulses.
  - If CASET or PASET has fewer than 4 params, the pending window is discarded and protocol_err pulses.
  - Next state: 0x2A→CASET, 0x2B→PASET, 0x2C→RAMWR, any other code→IGNORE.
- CASET: collect 4 bytes: SC_hi, SC_lo, EC_hi, EC_lo.
  - On the 4th byte, if SC≤EC<WIDTH, commit SC/EC. Otherwise keep the old window and pulse protocol_err.
  - Bytes beyond the 4th are ignored silently.
- PASET: same as CASET, using SP/EP and HEIGHT.
- RAMWR entry: cursor=(SC,SP); frame_start pulses the next cycle.
- RAMWR data: byte 0 is the high byte and is held; byte 1 is the low byte and completes the RGB565 word.
  - Next cycle: pxl_valid=1, pxl_x/pxl_y = cursor, pxl_rgb = {R5[4:1], G6[5:2], B5[4:1]}.
  - Cursor then advances:
    - x≠EC: x+1.
    - x=EC, y≠EP: x=SC, y+1.
    - x=EC, y=EP: wrap to (SC,SP). No extra frame_start.
- IGNORE: data bytes are discarded with no error.
- IDLE data byte (no command since reset): discarded; protocol_err pulses.

Timing and simultaneity:
- lcd_rd low while a write event occurs: protocol_err pulses; the byte is still decoded.
- Latency: every output pulse occurs exactly 1 clk after the write event cycle (SYNC_STAGES+1 clk after the pin edge).
- At most one event per write, so cmd_valid and pxl_valid are never high together.
- protocol_err may coincide with cmd_valid; if so, it is a single pulse.
- pxl_x, pxl_y, pxl_rgb and cmd_code hold their values between pulses.

Test Plan:
1. Reset, then cmd 0x2C and pixel bytes 0xF8,0x00 → frame_start once; pxl_valid with (0,0), rgb=0xF00; next pixel at (1,0).
2. CASET 0,10,0,12; PASET 0,5,0,6; RAMWR; 7 pixels of 0x07E0 → coordinates (10,5),(11,5),(12,5),(10,6),(11,6),(12,6),(10,5); rgb=0x0F0 each; frame_start only once.
3. CASET 0,20,0,10 (SC>EC) → protocol_err 1 pulse; the next RAMWR starts at the old SC.
4. RAMWR, single byte 0xFF, then cmd 0x2A → no pxl_valid; protocol_err 1 pulse; cmd_valid with cmd_code=0x2A.
5. Mid-RAMWR, assert lcd_reset low 10 clk, then release; send RAMWR and one pixel → pxl at (0,0), default window restored; resetN low mid-pixel clears all outputs immediately (async).
6. Unknown cmd 0x11 followed by 3 data bytes → cmd_valid with cmd_code=0x11; no pxl_valid; no protocol_err.
